fft_stage_sequencer: RTL and testbench

// - Sequences a radix-2 DIT FFT of 2^LOG2N points through LOG2N butterfly stages with a start/busy/done handshake.
// - Each active cycle it issues one butterfly: operand addresses A/B and a twiddle-ROM index.
// - Sits between the top-level FFT control and the butterfly datapath and twiddle ROM.
// - Replaces free-running twiddle counters with deterministic, restartable scheduling.

---
 rtl/fft_stage_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_stage_sequencer
// Description : Sequences a radix-2 DIT FFT of 2^LOG2N points through LOG2N
//               butterfly stages. Each RUN cycle it issues one butterfly
//               (operand addresses A/B plus twiddle-ROM index). Optional
//               idle bubbles separate stages so the datapath can drain.
//               Define FFT_SEQ_PIPE_EN to register the datapath-facing
//               outputs (bf_valid, stage, addr_a, addr_b, tw_idx, done)
//               through one extra stage; busy stays undelayed.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer #(
  parameter int LOG2N     = 3,
  parameter int STAGE_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             bf_valid,
  output logic [3:0]       stage,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             done
);

  localparam int JW = LOG2N - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [JW-1:0] J_LAST     = '1;
  localparam logic [3:0]    STAGE_LAST = 4'(LOG2N - 1);
  localparam logic [3:0]    GAP_LAST   = 4'((STAGE_GAP == 0) ? 0 : STAGE_GAP - 1);
  // With no bubble requested the next stage starts straight out of RUN.
  localparam logic [1:0]    S_AFTER_STAGE = (STAGE_GAP == 0) ? S_RUN : S_GAP;

  logic [1:0]    state;
  logic [JW-1:0] bfly_cnt;
  logic [3:0]    stage_cnt;
  logic [3:0]    gap_cnt;
  logic          accept_start;

  // Combinationally decoded outputs, before the optional pipeline stage.
  logic             active;
  logic [LOG2N-1:0] j_ext;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] mask;
  logic [JW-1:0]    k_val;
  logic             bf_valid_d;
  logic             done_d;
  logic [3:0]       stage_d;
  logic [LOG2N-1:0] addr_a_d;
  logic [LOG2N-1:0] addr_b_d;
  logic [LOG2N-2:0] tw_idx_d;

`ifdef FFT_SEQ_PIPE_EN
  logic             done_q;
  // A delayed done still counts as busy, so a new start waits for it to clear.
  assign accept_start = start & ~done_q;
`else
  assign accept_start = start;
`endif

  // Control FSM with butterfly, stage and bubble counters; stall freezes RUN/GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bfly_cnt  <= '0;
      stage_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_start) begin
            state     <= S_RUN;
            bfly_cnt  <= '0;
            stage_cnt <= '0;
            gap_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (bfly_cnt == J_LAST) begin
              bfly_cnt <= '0;
              gap_cnt  <= '0;
              if (stage_cnt == STAGE_LAST) begin
                stage_cnt <= '0;
                state     <= S_DONE;
              end else begin
                stage_cnt <= stage_cnt + 4'd1;
                state     <= S_AFTER_STAGE;
              end
            end else begin
              bfly_cnt <= bfly_cnt + JW'(1);
            end
          end
        end
        S_GAP: begin
          if (!stall) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              state   <= S_RUN;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Address/twiddle decode: split j into group g (high bits) and offset k
  // (low s bits); inserting a zero at bit s gives addr_a, setting it gives addr_b.
  always_comb begin
    active     = (state == S_RUN) || (state == S_GAP);
    j_ext      = {1'b0, bfly_cnt};
    half       = LOG2N'(1) << stage_cnt;
    mask       = half - LOG2N'(1);
    k_val      = bfly_cnt & mask[JW-1:0];
    bf_valid_d = (state == S_RUN) & ~stall;
    done_d     = (state == S_DONE);
    stage_d    = '0;
    addr_a_d   = '0;
    addr_b_d   = '0;
    tw_idx_d   = '0;
    if (active) begin
      stage_d  = stage_cnt;
      addr_a_d = ((j_ext & ~mask) << 1) | (j_ext & mask);
      addr_b_d = addr_a_d + half;
      tw_idx_d = k_val << (STAGE_LAST - stage_cnt);
    end
  end

`ifdef FFT_SEQ_PIPE_EN
  logic             bf_valid_q;
  logic [3:0]       stage_q;
  logic [LOG2N-1:0] addr_a_q;
  logic [LOG2N-1:0] addr_b_q;
  logic [LOG2N-2:0] tw_idx_q;

  // One-cycle output register stage toward the datapath and twiddle ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_valid_q <= 1'b0;
      done_q     <= 1'b0;
      stage_q    <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      tw_idx_q   <= '0;
    end else begin
      bf_valid_q <= bf_valid_d;
      done_q     <= done_d;
      stage_q    <= stage_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      tw_idx_q   <= tw_idx_d;
    end
  end

  assign busy     = (state != S_IDLE) | done_q;
  assign bf_valid = bf_valid_q;
  assign done     = done_q;
  assign stage    = stage_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign tw_idx   = tw_idx_q;
`else
  assign busy     = (state != S_IDLE);
  assign bf_valid = bf_valid_d;
  assign done     = done_d;
  assign stage    = stage_d;
  assign addr_a   = addr_a_d;
  assign addr_b   = addr_b_d;
  assign tw_idx   = tw_idx_d;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_stage_sequencer
// Description : Randomized self-checking bench. A schedule of butterflies,
//               bubbles and the done slot is built from the FFT indexing
//               rules; a pointer walks it, advancing only on unstalled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_stage_sequencer;

  localparam int L  = 3;
  localparam int G  = 2;
  localparam int NB = 1 << (L - 1);

  localparam int K_BF   = 0;
  localparam int K_GAP  = 1;
  localparam int K_DONE = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;

  logic       busy, bf_valid, done;
  logic [3:0] stage;
  logic [2:0] addr_a, addr_b;
  logic [1:0] tw_idx;

  logic       busy_z, bf_valid_z, done_z;
  logic [3:0] stage_z;
  logic [2:0] addr_a_z, addr_b_z;
  logic [1:0] tw_idx_z;

  fft_stage_sequencer #(.LOG2N(L), .STAGE_GAP(G)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .busy(busy), .bf_valid(bf_valid), .stage(stage),
    .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx), .done(done)
  );

  fft_stage_sequencer #(.LOG2N(L), .STAGE_GAP(0)) u_dut_nogap (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .busy(busy_z), .bf_valid(bf_valid_z), .stage(stage_z),
    .addr_a(addr_a_z), .addr_b(addr_b_z), .tw_idx(tw_idx_z), .done(done_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int a;
    int b;
    int tw;
    int s;
  } slot_t;

  slot_t sched[$];
  int vectors     = 0;
  int miscompares = 0;

  // Reference schedule straight from the DIT indexing formulas.
  function automatic void build_sched();
    slot_t e;
    sched.delete();
    for (int s = 0; s < L; s++) begin
      for (int j = 0; j < NB; j++) begin
        int half;
        int g;
        int k;
        half   = 1 << s;
        g      = j / half;
        k      = j % half;
        e.kind = K_BF;
        e.s    = s;
        e.a    = g * 2 * half + k;
        e.b    = e.a + half;
        e.tw   = k * (1 << (L - 1 - s));
        sched.push_back(e);
      end
      if (s < L - 1) begin
        for (int q = 0; q < G; q++) begin
          e.kind = K_GAP; e.s = 0; e.a = 0; e.b = 0; e.tw = 0;
          sched.push_back(e);
        end
      end
    end
    e.kind = K_DONE; e.s = 0; e.a = 0; e.b = 0; e.tw = 0;
    sched.push_back(e);
  endfunction

  // One transform from IDLE with random stalls and optional start pokes while busy.
  task automatic run_transform(input int stall_pct, input bit poke_start, input bit check_nogap);
    int ptr;
    int n;
    bit fin;
    logic [14:0] got;
    logic [14:0] exp;
    logic [2:0]  got3;
    logic [2:0]  exp3;
    ptr = 0; n = 0; fin = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      n++;
      stall = ($urandom_range(0, 99) < stall_pct);
      start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      vectors++;
      if (sched[ptr].kind == K_BF) begin
        exp = {1'b1, 1'b0, ~stall, 4'(sched[ptr].s), 3'(sched[ptr].a),
               3'(sched[ptr].b), 2'(sched[ptr].tw)};
        got = {busy, done, bf_valid, stage, addr_a, addr_b, tw_idx};
        if (got !== exp) begin
          miscompares++;
          $display("FAIL bfly cyc=%0d slot=%0d got=%h expected=%h", n, ptr, got, exp);
        end
      end else begin
        exp3 = {1'b1, sched[ptr].kind == K_DONE, 1'b0};
        got3 = {busy, done, bf_valid};
        if (got3 !== exp3) begin
          miscompares++;
          $display("FAIL ctrl cyc=%0d slot=%0d busy/done/valid got=%b expected=%b", n, ptr, got3, exp3);
        end
      end
      if (check_nogap) begin
        vectors++;
        if ({bf_valid_z, done_z} !== {n <= 12, n == 13}) begin
          miscompares++;
          $display("FAIL nogap cyc=%0d valid/done got=%b%b expected=%b%b",
                   n, bf_valid_z, done_z, n <= 12, n == 13);
        end
      end
      if (sched[ptr].kind == K_DONE) fin = 1;
      @(posedge clk); #1;
      if (!stall) ptr++;
    end
    start = 1'b0;
    stall = 1'b0;
    if (!fin) begin
      miscompares++;
      $display("FAIL timeout got=no_done expected=done");
    end
    @(negedge clk);
    vectors++;
    if ({busy, done, bf_valid, stage, addr_a, addr_b, tw_idx} !== 15'd0) begin
      miscompares++;
      $display("FAIL post_idle got=%h expected=0", {busy, done, bf_valid, stage, addr_a, addr_b, tw_idx});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, bf_valid, stage, addr_a, addr_b, tw_idx,
         busy_z, done_z, bf_valid_z, stage_z, addr_a_z, addr_b_z, tw_idx_z} !== 30'd0) begin
      miscompares++;
      $display("FAIL reset got=%h/%h expected=0",
               {busy, done, bf_valid, stage, addr_a, addr_b, tw_idx},
               {busy_z, done_z, bf_valid_z, stage_z, addr_a_z, addr_b_z, tw_idx_z});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    run_transform(0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    for (int r = 0; r < 3; r++) run_transform(30, 1'b0, 1'b0);
    run_transform(60, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    for (int r = 0; r < 2; r++) run_transform(20, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if ({bf_valid, stage} !== {1'b1, 4'd1}) begin
      miscompares++;
      $display("FAIL pre_abort valid/stage got=%b/%0d expected=1/1", bf_valid, stage);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, bf_valid, stage, addr_a, addr_b, tw_idx} !== 15'd0) begin
      miscompares++;
      $display("FAIL async_reset got=%h expected=0", {busy, done, bf_valid, stage, addr_a, addr_b, tw_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done} !== 2'b00) begin
        miscompares++;
        $display("FAIL aborted cyc=%0d busy/done got=%b%b expected=00", c, busy, done);
      end
    end
    run_transform(0, 1'b0, 1'b0);
  endtask

  task automatic test_start_held();
    int n;
    bit seen;
    n = 0; seen = 0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen || n != 17) begin
      miscompares++;
      $display("FAIL held_done_cycle got=%0d expected=17", seen ? n : -1);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL held_idle busy/done got=%b%b expected=00", busy, done);
    end
    @(negedge clk);
    vectors++;
    if ({busy, bf_valid, addr_a, addr_b, tw_idx} !== {1'b1, 1'b1, 3'd0, 3'd1, 2'd0}) begin
      miscompares++;
      $display("FAIL held_restart got=%b%b a=%0d b=%0d tw=%0d expected=11 a=0 b=1 tw=0",
               busy, bf_valid, addr_a, addr_b, tw_idx);
    end
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL held_second_done got=none expected=done");
    end
    @(negedge clk);
  endtask

  initial begin
    build_sched();
    test_reset();
    test_nominal();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_start_held();
    test_nominal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
